// File: rtl/router_pkg.sv
// Shared types and default sizing for the flash-router FIFO scheduler.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    localparam int DEF_SA_ROWS     = 8;
    localparam int DEF_DATA_LENGTH = 9;
    localparam int DEF_CNT_WIDTH   = 16;

endpackage

// File: rtl/skew_pop_gen.sv
// Diagonally skewed pop enables for the FIFO bank: row r drains during
// cycles d = r .. r+len[r]-1 of the DRAIN phase, one cycle behind d.
module skew_pop_gen
    import router_pkg::*;
#(
    parameter int SA_ROWS   = DEF_SA_ROWS,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                               i_clk,
    input  logic                               i_nrst,
    input  logic                               i_clear,
    input  logic                               i_drain,
    input  logic [CNT_WIDTH-1:0]               i_d,
    input  logic [SA_ROWS-1:0][CNT_WIDTH-1:0]  i_len,
    input  logic [SA_ROWS-1:0]                 i_fifo_empty,
    output logic [SA_ROWS-1:0]                 o_pop_en
);

    logic [SA_ROWS-1:0] pop_d;
    logic [SA_ROWS-1:0] pop_q;

    // NOTE: every bit gets a default before the loop so no latch is inferred.
    always_comb begin
        pop_d = '0;
        for (int r = 0; r < SA_ROWS; r++) begin
            pop_d[r] = i_drain && !i_clear
                       && (i_d >= CNT_WIDTH'(r))
                       && ((i_d - CNT_WIDTH'(r)) < i_len[r])
                       && !i_fifo_empty[r];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) pop_q <= '0;
        else         pop_q <= pop_d;
    end

    assign o_pop_en = pop_q;

endmodule

// File: rtl/router_fifo_scheduler.sv
// FILL/DRAIN sequencer for the per-row MISO FIFO bank of the flash router.
// Define ROUTER_SCHED_PERF_EN to add the o_stall_cycles back-pressure counter.
module router_fifo_scheduler
    import router_pkg::*;
#(
    parameter int SA_ROWS     = DEF_SA_ROWS,
    parameter int SA_BITS     = $clog2(SA_ROWS),
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_clear,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_win_count,
    input  logic                 i_win_valid,
    output logic                 o_win_ready,
    output logic                 o_write_en,
    output logic [SA_BITS-1:0]   o_current_row,
    input  logic [SA_ROWS-1:0]   i_fifo_full,
    input  logic [SA_ROWS-1:0]   i_fifo_empty,
    output logic [SA_ROWS-1:0]   o_pop_en,
    output logic                 o_fifo_clear,
`ifdef ROUTER_SCHED_PERF_EN
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
`endif
    output logic                 o_busy,
    output logic                 o_done
);

    sched_state_e                      state_q;
    logic [CNT_WIDTH-1:0]              count_q;
    logic [CNT_WIDTH-1:0]              win_cnt_q;
    logic [CNT_WIDTH-1:0]              d_q;
    logic [SA_BITS-1:0]                row_cnt_q;
    logic [SA_ROWS-1:0][CNT_WIDTH-1:0] len_q;
    logic                              fifo_clear_q;
    logic                              handshake;
    logic                              last_win;

    // A clear in the same cycle blocks the handshake so no write escapes the abort.
    assign o_win_ready   = (state_q == FILL) && !i_fifo_full[row_cnt_q] && !i_clear;
    assign handshake     = o_win_ready && i_win_valid;
    assign o_write_en    = handshake;
    assign o_current_row = row_cnt_q;
    assign last_win      = (win_cnt_q + CNT_WIDTH'(1)) == count_q;
    assign o_busy        = (state_q == FILL) || (state_q == DRAIN);
    assign o_done        = (state_q == DONE);
    assign o_fifo_clear  = fifo_clear_q;

    // NOTE: the per-row length array is only SA_ROWS counters, so it is reset
    // with the rest of the state rather than treated as an uninitialised memory.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            win_cnt_q    <= '0;
            d_q          <= '0;
            row_cnt_q    <= '0;
            len_q        <= '0;
            fifo_clear_q <= 1'b0;
        end else begin
            fifo_clear_q <= 1'b0;
            if (i_clear) begin
                state_q      <= IDLE;
                win_cnt_q    <= '0;
                d_q          <= '0;
                row_cnt_q    <= '0;
                len_q        <= '0;
                fifo_clear_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            count_q      <= i_win_count;
                            win_cnt_q    <= '0;
                            d_q          <= '0;
                            row_cnt_q    <= '0;
                            len_q        <= '0;
                            fifo_clear_q <= 1'b1;
                            state_q      <= (i_win_count == '0) ? DONE : FILL;
                        end
                    end
                    FILL: begin
                        if (handshake) begin
                            len_q[row_cnt_q] <= len_q[row_cnt_q] + CNT_WIDTH'(DATA_LENGTH);
                            row_cnt_q <= (row_cnt_q == SA_BITS'(SA_ROWS - 1))
                                         ? '0 : row_cnt_q + SA_BITS'(1);
                            win_cnt_q <= win_cnt_q + CNT_WIDTH'(1);
                            if (last_win) begin
                                state_q <= DRAIN;
                                d_q     <= '0;
                            end
                        end
                    end
                    DRAIN: begin
                        d_q <= d_q + CNT_WIDTH'(1);
                        // Row 0 got the first window, so its length bounds the skew tail.
                        if (d_q == CNT_WIDTH'(SA_ROWS - 1) + len_q[0]) state_q <= DONE;
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    skew_pop_gen #(
        .SA_ROWS   (SA_ROWS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_skew_pop_gen (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_clear      (i_clear),
        .i_drain      (state_q == DRAIN),
        .i_d          (d_q),
        .i_len        (len_q),
        .i_fifo_empty (i_fifo_empty),
        .o_pop_en     (o_pop_en)
    );

`ifdef ROUTER_SCHED_PERF_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            stall_q <= '0;
        end else if (i_clear || ((state_q == IDLE) && i_start)) begin
            stall_q <= '0;
        end else if ((state_q == FILL) && i_win_valid && !o_win_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_router_fifo_scheduler.sv
// Self-checking bench for router_fifo_scheduler: window-level reference model
// compared every cycle, plus directed passes pinned to hand-derived latencies.
module tb_router_fifo_scheduler;

    localparam int SA_ROWS = 8;
    localparam int DL      = 9;

    logic        clk        = 1'b0;
    logic        nrst       = 1'b0;
    logic        clear      = 1'b0;
    logic        start      = 1'b0;
    logic [15:0] win_count  = '0;
    logic        win_valid  = 1'b0;
    logic [7:0]  fifo_full  = '0;
    logic [7:0]  fifo_empty = '0;

    logic        o_win_ready, o_write_en, o_fifo_clear, o_busy, o_done;
    logic [2:0]  o_current_row;
    logic [7:0]  o_pop_en;
`ifdef ROUTER_SCHED_PERF_EN
    logic [15:0] o_stall_cycles;
`endif

    router_fifo_scheduler dut (
        .i_clk         (clk),
        .i_nrst        (nrst),
        .i_clear       (clear),
        .i_start       (start),
        .i_win_count   (win_count),
        .i_win_valid   (win_valid),
        .o_win_ready   (o_win_ready),
        .o_write_en    (o_write_en),
        .o_current_row (o_current_row),
        .i_fifo_full   (fifo_full),
        .i_fifo_empty  (fifo_empty),
        .o_pop_en      (o_pop_en),
        .o_fifo_clear  (o_fifo_clear),
`ifdef ROUTER_SCHED_PERF_EN
        .o_stall_cycles(o_stall_cycles),
`endif
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (window/pass level) ----------------
    // phase: 0 idle, 1 filling, 2 draining, 3 done-pulse
    int         m_phase = 0;
    int         m_count = 0;
    int         m_acc   = 0;   // windows accepted so far this pass
    int         m_k     = 0;   // drain cycle index
    int         m_len[SA_ROWS];
    int         m_maxlen = 0;
    logic [7:0] m_pop   = '0;
    logic       m_fclr  = 1'b0;
    int         m_stall = 0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_phase = 0; m_count = 0; m_acc = 0; m_k = 0;
            m_pop = '0; m_fclr = 1'b0; m_stall = 0;
        end else begin
            m_fclr = 1'b0;
            m_pop  = '0;
            if (clear) begin
                m_phase = 0; m_acc = 0; m_k = 0; m_fclr = 1'b1; m_stall = 0;
            end else if (m_phase == 0) begin
                if (start) begin
                    m_count = int'(win_count);
                    m_acc = 0; m_k = 0; m_fclr = 1'b1; m_stall = 0;
                    m_phase = (win_count == 0) ? 3 : 1;
                end
            end else if (m_phase == 1) begin
                if (win_valid && !fifo_full[m_acc % SA_ROWS]) begin
                    m_acc++;
                    if (m_acc == m_count) begin
                        // Window i lands in row i % SA_ROWS, each adding DL words.
                        m_maxlen = 0;
                        for (int r = 0; r < SA_ROWS; r++) begin
                            m_len[r] = DL * (m_count / SA_ROWS + ((r < m_count % SA_ROWS) ? 1 : 0));
                            if (m_len[r] > m_maxlen) m_maxlen = m_len[r];
                        end
                        m_phase = 2; m_k = 0;
                    end
                end else if (win_valid && m_stall < 65535) begin
                    m_stall++;
                end
            end else if (m_phase == 2) begin
                for (int r = 0; r < SA_ROWS; r++)
                    m_pop[r] = (m_k >= r) && (m_k < r + m_len[r]) && !fifo_empty[r];
                if (m_k == SA_ROWS - 1 + m_maxlen) m_phase = 3;
                m_k++;
            end else begin
                m_phase = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (nrst) begin
            logic exp_ready;
            exp_ready = (m_phase == 1) && !fifo_full[m_acc % SA_ROWS] && !clear;
            check("win_ready",   o_win_ready,   exp_ready);
            check("write_en",    o_write_en,    exp_ready && win_valid);
            check("current_row", o_current_row, m_acc % SA_ROWS);
            check("pop_en",      o_pop_en,      m_pop);
            check("busy",        o_busy,        (m_phase == 1) || (m_phase == 2));
            check("done",        o_done,        m_phase == 3);
            check("fifo_clear",  o_fifo_clear,  m_fclr);
`ifdef ROUTER_SCHED_PERF_EN
            check("stall_cycles", o_stall_cycles, m_stall);
`endif
        end
    end

    // ---------------- directed stimulus helpers ----------------
    int wr_rows[$];
    int pop_cnt[SA_ROWS];
    int done_c, fclr_c, ready_low;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One pass with valid held high and no empties; row 2 optionally full
    // during cycles [stall_c0, stall_c0+stall_n) counted from the start edge.
    task automatic directed_pass(input int cnt, input int stall_c0, input int stall_n);
        wr_rows.delete();
        for (int r = 0; r < SA_ROWS; r++) pop_cnt[r] = 0;
        done_c = -1; fclr_c = -1; ready_low = 0;
        win_valid = 1'b1; fifo_full = '0; fifo_empty = '0;
        win_count = 16'(cnt); start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            fifo_full = (stall_n > 0 && c >= stall_c0 && c < stall_c0 + stall_n) ? 8'h04 : 8'h00;
            #1;
            if (o_write_en) wr_rows.push_back(int'(o_current_row));
            if (o_busy && !o_win_ready && o_current_row == 3'd2) ready_low++;
            for (int r = 0; r < SA_ROWS; r++) pop_cnt[r] += int'(o_pop_en[r]);
            if (o_fifo_clear && fclr_c < 0) fclr_c = c;
            if (o_done) begin
                done_c = c;
                break;
            end
            cyc();
        end
        fifo_full = '0;
        win_valid = 1'b0;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int done_pulses;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_pop", o_pop_en, 0);
        check("rst_fifo_clear", o_fifo_clear, 0);
        check("rst_row", o_current_row, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        cyc();

        // Eight windows, one per row, back to back
        directed_pass(8, 0, 0);
        check("p8_done_latency", done_c, 26);
        check("p8_writes", wr_rows.size(), 8);
        for (int i = 0; i < wr_rows.size(); i++) check("p8_write_row", wr_rows[i], i);
        for (int r = 0; r < SA_ROWS; r++) check("p8_pops_per_row", pop_cnt[r], 9);
        check("p8_fifo_clear_cycle", fclr_c, 1);

        // Three windows: rows 3..7 stay silent, drain still spans 17 cycles
        directed_pass(3, 0, 0);
        check("p3_done_latency", done_c, 21);
        check("p3_writes", wr_rows.size(), 3);
        for (int r = 0; r < SA_ROWS; r++) check("p3_pops_per_row", pop_cnt[r], (r < 3) ? 9 : 0);

        // Row 2 full for four cycles: FILL stalls on row 2, nothing skipped
        directed_pass(8, 3, 4);
        check("stall_done_latency", done_c, 30);
        check("stall_ready_low", ready_low, 4);
        check("stall_writes", wr_rows.size(), 8);
        for (int i = 0; i < wr_rows.size(); i++) check("stall_write_row", wr_rows[i], i);
`ifdef ROUTER_SCHED_PERF_EN
        check("stall_counter", o_stall_cycles, 4);
`endif

        // Zero-window pass
        directed_pass(0, 0, 0);
        check("p0_done_latency", done_c, 1);
        check("p0_fifo_clear_cycle", fclr_c, 1);
        check("p0_writes", wr_rows.size(), 0);
        check("p0_pops_row0", pop_cnt[0], 0);

        // Clear during DRAIN at d = 5
        win_valid = 1'b1; win_count = 16'd8; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (13) cyc();
        check("clr_pop_before", o_pop_en, 8'h1F);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_pop_after", o_pop_en, 0);
        check("clr_busy_after", o_busy, 0);
        check("clr_fifo_clear", o_fifo_clear, 1);
        done_pulses = 0;
        for (int c = 0; c < 20; c++) begin
            done_pulses += int'(o_done);
            cyc();
        end
        check("clr_no_done", done_pulses, 0);
        win_valid = 1'b0;

        // Async reset mid-FILL, then a 16-window pass
        win_valid = 1'b1; win_count = 16'd8; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        nrst = 1'b0;
        #2;
        check("arst_busy", o_busy, 0);
        check("arst_write_en", o_write_en, 0);
        check("arst_row", o_current_row, 0);
        cyc();
        nrst = 1'b1;
        directed_pass(16, 0, 0);
        check("p16_done_latency", done_c, 43);
        check("p16_writes", wr_rows.size(), 16);
        for (int r = 0; r < SA_ROWS; r++) check("p16_pops_per_row", pop_cnt[r], 18);

        // Randomized passes against the reference model
        for (int p = 0; p < 25; p++) begin
            win_count = 16'($urandom_range(0, 20));
            start = 1'b1;
            cyc();
            start = 1'b0;
            for (int c = 0; c < 300; c++) begin
                win_valid  = ($urandom_range(0, 99) < 70);
                fifo_full  = '0;
                fifo_empty = '0;
                for (int r = 0; r < SA_ROWS; r++) begin
                    fifo_full[r]  = ($urandom_range(0, 99) < 15);
                    fifo_empty[r] = ($urandom_range(0, 99) < 10);
                end
                start = ($urandom_range(0, 99) < 3);
                clear = ($urandom_range(0, 99) < 1);
                cyc();
                if (!o_busy) break;
            end
            check("rand_pass_ended", o_busy, 0);
            start = 1'b0; clear = 1'b0; win_valid = 1'b0;
            fifo_full = '0; fifo_empty = '0;
            repeat (2) cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
